// File: rtl/spi_flash_pkg.sv
// Shared command codes, FSM encoding and byte-lane helper for the SPI flash responder.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_RDSR   = 8'h05;
    localparam int         ADDR_BYTES = 3;
    localparam int         ADDR_BITS  = ADDR_BYTES * 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        STAT,
        IGNORE
    } state_e;

    // Big-endian lane select: sel 0 is the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Oversampling front end: synchronises SCK, SS and MOSI and flags SCK rise/fall and SS fall.
module spi_slave_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic sck_rise_o,
    output logic sck_fall_o,
    output logic ss_fall_o,
    output logic ss_high_o,
    output logic mosi_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ss_prev_q;

    // SS resets to its inactive level so leaving reset never looks like a select.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every stage one clock apart; blocking ones would collapse the chain.
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_rise_o = sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall_o = ~sck_sync_q[SYNC_STAGES-1] & sck_prev_q;
    assign ss_fall_o  = ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
    assign ss_high_o  = ss_sync_q[SYNC_STAGES-1];
    assign mosi_o     = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulation: answers READ (0x03) from a word-wide memory port and READ STATUS (0x05).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int MEM_DATA_WIDTH    = 32,
    parameter int MEM_ADDRESS_WIDTH = 13,
    parameter int SYNC_STAGES       = 2
) (
    input  logic                         master_clk_i,
    input  logic                         master_rst_i,
    input  logic                         SCK_SPI,
    input  logic                         SS,
    input  logic                         MOSI,
    output logic                         MISO,
    output logic [MEM_ADDRESS_WIDTH-1:0] mem_address_o,
    output logic                         mem_re_o,
    input  logic [MEM_DATA_WIDTH-1:0]    mem_data_i,
    input  logic [7:0]                   status_i,
    output logic                         active_o,
    output logic                         error_o
);

    // Only the address bits that reach the memory port are kept; higher ones shift out unused.
    localparam int SHIFT_W = (MEM_ADDRESS_WIDTH + 1 > 7) ? MEM_ADDRESS_WIDTH + 1 : 7;

    logic sck_rise, sck_fall, ss_fall, ss_high, mosi_s;

    spi_slave_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i     (master_clk_i),
        .rst_i     (master_rst_i),
        .sck_i     (SCK_SPI),
        .ss_i      (SS),
        .mosi_i    (MOSI),
        .sck_rise_o(sck_rise),
        .sck_fall_o(sck_fall),
        .ss_fall_o (ss_fall),
        .ss_high_o (ss_high),
        .mosi_o    (mosi_s)
    );

    state_e                         state_q;
    logic [4:0]                     bit_cnt_q;
    logic [SHIFT_W-1:0]             shift_q;
    logic [7:0]                     tx_q;
    logic                           miso_q;
    logic [MEM_ADDRESS_WIDTH-1:0]   mem_address_q;
    logic                           mem_re_q;
    logic                           rd_pend_q;
    logic [1:0]                     byte_sel_q;
    logic                           active_q;
    logic                           error_q;
    logic [MEM_DATA_WIDTH-1:0]      buf_q;

    logic [7:0] cmd_d;
    logic [7:0] tx_byte_d;

    assign cmd_d     = {shift_q[6:0], mosi_s};
    assign tx_byte_d = (state_q == DATA) ? word_byte(buf_q, byte_sel_q) : status_i;

    always_ff @(posedge master_clk_i or posedge master_rst_i) begin
        if (master_rst_i) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            miso_q        <= 1'b0;
            mem_address_q <= '0;
            mem_re_q      <= 1'b0;
            rd_pend_q     <= 1'b0;
            byte_sel_q    <= '0;
            active_q      <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            mem_re_q  <= 1'b0;
            error_q   <= 1'b0;
            rd_pend_q <= mem_re_q;

            // A deselect overrides any SCK edge seen in the same cycle.
            if (ss_high) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                miso_q    <= 1'b0;
                active_q  <= 1'b0;
            end else if (ss_fall) begin
                state_q   <= CMD;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    CMD: begin
                        if (sck_rise) begin
                            shift_q <= {shift_q[SHIFT_W-2:0], mosi_s};
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= '0;
                                case (cmd_d)
                                    CMD_READ: begin
                                        state_q  <= ADDR;
                                        active_q <= 1'b1;
                                    end
                                    CMD_RDSR: begin
                                        state_q  <= STAT;
                                        active_q <= 1'b1;
                                    end
                                    default: begin
                                        state_q <= IGNORE;
                                        error_q <= 1'b1;
                                    end
                                endcase
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            shift_q <= {shift_q[SHIFT_W-2:0], mosi_s};
                            if (bit_cnt_q == 5'(ADDR_BITS - 1)) begin
                                mem_address_q <= shift_q[MEM_ADDRESS_WIDTH:1];
                                byte_sel_q    <= {shift_q[0], mosi_s};
                                mem_re_q      <= 1'b1;
                                bit_cnt_q     <= '0;
                                state_q       <= DATA;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
                    DATA, STAT: begin
                        if (sck_fall) begin
                            if (bit_cnt_q == 5'd0) begin
                                miso_q <= tx_byte_d[7];
                                tx_q   <= {tx_byte_d[6:0], 1'b0};
                                if (state_q == DATA) begin
                                    byte_sel_q <= byte_sel_q + 2'd1;
                                    // Last lane of the word goes out: prefetch the next word now.
                                    if (byte_sel_q == 2'd3) begin
                                        mem_address_q <= mem_address_q + MEM_ADDRESS_WIDTH'(1);
                                        mem_re_q      <= 1'b1;
                                    end
                                end
                            end else begin
                                miso_q <= tx_q[7];
                                tx_q   <= {tx_q[6:0], 1'b0};
                            end
                            bit_cnt_q <= (bit_cnt_q == 5'd7) ? 5'd0 : bit_cnt_q + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the word buffer is pure datapath, always written before it is read, so it carries no reset.
    always_ff @(posedge master_clk_i) begin
        if (rd_pend_q) begin
            buf_q <= mem_data_i;
        end
    end

    assign MISO          = miso_q;
    assign mem_address_o = mem_address_q;
    assign mem_re_o      = mem_re_q;
    assign active_o      = active_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench: a SPI master drives random traffic, a byte-level flash model predicts MISO and memory reads.
module tb_spi_flash_responder;

    localparam int AW    = 13;
    localparam int WORDS = 1 << AW;
    localparam int HALF  = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          SCK, SS, MOSI, MISO;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [31:0]   mem_data;
    logic [7:0]    status;
    logic          active, error;

    always #5 clk = ~clk;

    spi_flash_responder dut (
        .master_clk_i (clk),
        .master_rst_i (rst),
        .SCK_SPI      (SCK),
        .SS           (SS),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .mem_address_o(mem_addr),
        .mem_re_o     (mem_re),
        .mem_data_i   (mem_data),
        .status_i     (status),
        .active_o     (active),
        .error_o      (error)
    );

    logic [31:0] mem [0:WORDS-1];

    always @(posedge clk) if (mem_re) mem_data <= mem[mem_addr];

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            err_seen = 0;
    int            exp_err  = 0;
    logic [7:0]    exp_miso[$];
    logic [AW-1:0] exp_re[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MISO monitor: master samples on SCK rise; a partial byte is dropped on deselect.
    int         mon_bits = 0;
    logic [7:0] mon_sh;
    always @(posedge SCK or posedge SS) begin
        if (SS === 1'b1) begin
            mon_bits = 0;
        end else begin
            mon_sh = {mon_sh[6:0], MISO};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_miso.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL miso_unexpected: got byte %h, expected none", mon_sh);
                end else begin
                    check("miso_byte", mon_sh, exp_miso.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mem_re === 1'b1) begin
            if (exp_re.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL mem_re_unexpected: got read of word %h, expected none", mem_addr);
            end else begin
                check("mem_re_addr", mem_addr, exp_re.pop_front());
            end
        end
        if (error === 1'b1) err_seen++;
    end

    function automatic logic [7:0] model_byte(input int unsigned b);
        int unsigned bb;
        logic [31:0] w;
        bb = b % (4 * WORDS);
        w  = mem[bb / 4];
        return w[8 * (3 - (bb % 4)) +: 8];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7 - i];
            wait_clk(HALF);
            SCK = 1'b1;
            wait_clk(HALF);
            SCK = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic [7:0] exp);
        exp_miso.push_back(exp);
        spi_bits(b, 8);
        wait_clk(HALF);
    endtask

    task automatic begin_txn();
        SS = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_txn();
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(4);
        check("active_after_deselect", active, 1'b0);
        wait_clk(HALF);
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {MISO, mem_re, active, error, 19'(mem_addr)}, 32'h0);
    endtask

    // READ of n bytes; the master's trailing SCK fall after each byte makes the flash load n+1 bytes.
    task automatic do_read(input logic [23:0] addr, input int n, input bit rst_abort);
        int unsigned base;
        int unsigned b;
        base = int'(addr[14:0]);
        begin_txn();
        spi_byte(8'h03, 8'h00);
        spi_byte(addr[23:16], 8'h00);
        spi_byte(addr[15:8], 8'h00);
        exp_re.push_back(AW'(base / 4));
        for (int k = 0; k <= n; k++) begin
            b = (base + k) % (4 * WORDS);
            if (b % 4 == 3) exp_re.push_back(AW'((b / 4 + 1) % WORDS));
        end
        spi_byte(addr[7:0], 8'h00);
        check("active_in_read", active, 1'b1);
        for (int k = 0; k < n; k++) spi_byte(8'($urandom), model_byte(base + k));
        if (rst_abort) begin
            spi_bits(8'($urandom), 4);
            wait_clk(2);
            rst = 1'b1;
            #1;
            check_reset_outputs("reset_mid_data");
            SS  = 1'b1;
            SCK = 1'b0;
            wait_clk(3);
            check_reset_outputs("held_in_reset");
            rst = 1'b0;
            wait_clk(HALF);
        end else begin
            end_txn();
        end
    endtask

    // Status is loaded at the trailing fall of the previous byte, so byte i returns the value held during byte i-1.
    task automatic do_rdsr(input int n, input logic [7:0] first, input logic [7:0] second);
        logic [7:0] cur, nxt;
        cur    = first;
        status = cur;
        begin_txn();
        spi_byte(8'h05, 8'h00);
        check("active_in_rdsr", active, 1'b1);
        for (int i = 0; i < n; i++) begin
            nxt    = (i == 0) ? second : 8'($urandom);
            status = nxt;
            spi_byte(8'($urandom), cur);
            cur = nxt;
        end
        end_txn();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'h55667788;
        rst = 1'b1; SS = 1'b1; SCK = 1'b0; MOSI = 1'b0; status = 8'h00;
        wait_clk(3);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        wait_clk(4);
        check_reset_outputs("after_reset");

        do_read(24'h000000, 8, 1'b0);
        do_read(24'h000006, 6, 1'b0);
        do_read(24'h007FFC, 8, 1'b0);
        do_read(24'hA57FFE, 5, 1'b0);
        do_rdsr(2, 8'h01, 8'h00);

        // Unknown opcode: one error pulse, MISO quiet, no reads.
        begin_txn();
        spi_byte(8'h9F, 8'h00);
        exp_err++;
        for (int i = 0; i < 4; i++) spi_byte(8'($urandom), 8'h00);
        check("active_in_ignore", active, 1'b0);
        check("error_pulses", err_seen, exp_err);
        end_txn();
        do_read(24'h000010, 3, 1'b0);

        // Deselect in the middle of the address.
        begin_txn();
        spi_byte(8'h03, 8'h00);
        spi_byte(8'h00, 8'h00);
        spi_bits(8'hFF, 5);
        wait_clk(2);
        SS = 1'b1;
        wait_clk(4);
        check("active_after_addr_abort", active, 1'b0);
        wait_clk(HALF);
        do_read(24'h000004, 4, 1'b0);

        do_read(24'h000020, 3, 1'b1);
        do_read(24'h000000, 4, 1'b0);

        for (int t = 0; t < 6; t++) do_read(24'($urandom), int'($urandom_range(1, 9)), 1'b0);
        for (int t = 0; t < 3; t++) do_rdsr(int'($urandom_range(1, 4)), 8'($urandom), 8'($urandom));

        wait_clk(10);
        check("miso_queue_drained", exp_miso.size(), 0);
        check("mem_re_queue_drained", exp_re.size(), 0);
        check("error_pulses_total", err_seen, exp_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
